// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor state for the traffic-light safety stage.
package traffic_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_ENCODING  = 3'd1;
    localparam logic [2:0] FC_CONFLICT  = 3'd2;
    localparam logic [2:0] FC_SKIP_YEL  = 3'd3;
    localparam logic [2:0] FC_SHORT_YEL = 3'd4;

    typedef enum logic [1:0] {
        StStartup,
        StMonitor,
        StFlash
    } mon_state_e;

    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

endpackage

// File: rtl/light_dir_checker.sv
// Per-direction lamp checker: keeps the previous sample and the current yellow run length,
// and flags encoding, green-to-red and short-yellow conditions for the current sample.
module light_dir_checker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_in,
    output logic       one_hot,
    output logic       non_red,
    output logic       skip_yellow,
    output logic       short_yellow
);

    localparam int unsigned YW = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YMax = YW'(MIN_YELLOW);

    logic [2:0]    hist_q, hist_d;
    logic [YW-1:0] ycnt_q, ycnt_d;

    always_comb begin
        hist_d = light_in;
        ycnt_d = '0;
        if (light_in == YEL) begin
            ycnt_d = (ycnt_q == YMax) ? ycnt_q : ycnt_q + YW'(1);
        end
    end

    // History resets to red so the first monitored sample never sees a fake transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= RED;
            ycnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            ycnt_q <= ycnt_d;
        end
    end

    always_comb begin
        one_hot      = is_one_hot(light_in);
        non_red      = (light_in != RED);
        skip_yellow  = (hist_q == GRN) && (light_in == RED);
        short_yellow = (hist_q == YEL) && (light_in != YEL) && (ycnt_q < YMax);
    end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety stage between the light controller and lamp drivers: registers the lamps through,
// masks or latches on illegal patterns, and flashes all-red until an explicit clear.
module light_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW     = 3,
    parameter int unsigned FAULT_PERSIST  = 2,
    parameter int unsigned FLASH_HALF     = 4,
    parameter int unsigned STARTUP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] NS_light_in,
    input  logic [2:0] EW_light_in,
    input  logic       fault_clr,
    output logic [2:0] NS_light,
    output logic [2:0] EW_light,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int unsigned PW = (FAULT_PERSIST < 1) ? 1 : $clog2(FAULT_PERSIST + 1);
    localparam int unsigned SW = (STARTUP_CYCLES < 2) ? 1 : $clog2(STARTUP_CYCLES);
    localparam int unsigned FW = (FLASH_HALF < 1) ? 1 : $clog2(2 * FLASH_HALF);

    localparam logic [PW-1:0] PersistLast = PW'(FAULT_PERSIST - 1);
    localparam logic [SW-1:0] StartupLast = SW'(STARTUP_CYCLES - 1);
    localparam logic [FW-1:0] FlashLast   = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FlashHalf   = FW'(FLASH_HALF);

    mon_state_e    state_q, state_d;
    logic [SW-1:0] startup_cnt_q, startup_cnt_d;
    logic [PW-1:0] persist_cnt_q, persist_cnt_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic [2:0]    ns_q, ns_d;
    logic [2:0]    ew_q, ew_d;
    logic [2:0]    code_q, code_d;

    logic ns_one_hot, ns_non_red, ns_skip, ns_short;
    logic ew_one_hot, ew_non_red, ew_skip, ew_short;

    light_dir_checker #(
        .MIN_YELLOW (MIN_YELLOW)
    ) u_ns_checker (
        .clk          (clk),
        .rst          (rst),
        .light_in     (NS_light_in),
        .one_hot      (ns_one_hot),
        .non_red      (ns_non_red),
        .skip_yellow  (ns_skip),
        .short_yellow (ns_short)
    );

    light_dir_checker #(
        .MIN_YELLOW (MIN_YELLOW)
    ) u_ew_checker (
        .clk          (clk),
        .rst          (rst),
        .light_in     (EW_light_in),
        .one_hot      (ew_one_hot),
        .non_red      (ew_non_red),
        .skip_yellow  (ew_skip),
        .short_yellow (ew_short)
    );

    logic [2:0] code;
    logic       persist_err;
    logic       monitor_active;
    logic       trip;

    always_comb begin
        code = FC_NONE;
        if (!ns_one_hot || !ew_one_hot) begin
            code = FC_ENCODING;
        end else if (ns_non_red && ew_non_red) begin
            code = FC_CONFLICT;
        end else if (ns_skip || ew_skip) begin
            code = FC_SKIP_YEL;
        end else if (ns_short || ew_short) begin
            code = FC_SHORT_YEL;
        end
    end

    // The last startup cycle's sample is the first one passed through and checked.
    always_comb begin
        persist_err    = (code == FC_ENCODING) || (code == FC_CONFLICT);
        monitor_active = (state_q == StMonitor) ||
                         ((state_q == StStartup) && (startup_cnt_q == StartupLast));
        trip           = monitor_active &&
                         ((persist_err && (persist_cnt_q >= PersistLast)) ||
                          (!persist_err && (code != FC_NONE)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StStartup;
            startup_cnt_q <= '0;
            persist_cnt_q <= '0;
            flash_cnt_q   <= '0;
            ns_q          <= RED;
            ew_q          <= RED;
            code_q        <= FC_NONE;
        end else begin
            state_q       <= state_d;
            startup_cnt_q <= startup_cnt_d;
            persist_cnt_q <= persist_cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            ns_q          <= ns_d;
            ew_q          <= ew_d;
            code_q        <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStartup: begin
                if (trip) begin
                    state_d = StFlash;
                end else if (startup_cnt_q == StartupLast) begin
                    state_d = StMonitor;
                end
            end
            StMonitor: begin
                if (trip) begin
                    state_d = StFlash;
                end
            end
            StFlash: begin
                if (fault_clr) begin
                    state_d = StStartup;
                end
            end
            default: state_d = StStartup;
        endcase
    end

    always_comb begin
        startup_cnt_d = '0;
        persist_cnt_d = '0;
        flash_cnt_d   = '0;
        ns_d          = RED;
        ew_d          = RED;
        code_d        = code_q;

        if (state_q == StStartup && !monitor_active) begin
            startup_cnt_d = startup_cnt_q + SW'(1);
        end

        if (monitor_active) begin
            if (trip) begin
                code_d = code;
            end else if (persist_err) begin
                persist_cnt_d = persist_cnt_q + PW'(1);
            end else begin
                ns_d = NS_light_in;
                ew_d = EW_light_in;
            end
        end

        // Flash index 0 is the trip edge, so the first red half includes it.
        if (state_q == StFlash) begin
            if (fault_clr) begin
                code_d = FC_NONE;
            end else begin
                flash_cnt_d = (flash_cnt_q == FlashLast) ? '0 : flash_cnt_q + FW'(1);
                if (flash_cnt_d >= FlashHalf) begin
                    ns_d = OFF;
                    ew_d = OFF;
                end
            end
        end
    end

    always_comb begin
        NS_light   = ns_q;
        EW_light   = ew_q;
        fault      = (state_q == StFlash);
        fault_code = code_q;
    end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor: a sample-history model predicts every cycle,
// and literal checks at key points pin the model to hand-computed values.
module tb_light_conflict_monitor;

    localparam int MIN_YELLOW     = 3;
    localparam int FAULT_PERSIST  = 2;
    localparam int FLASH_HALF     = 4;
    localparam int STARTUP_CYCLES = 8;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_BAD = 3'b011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ns_in = L_GRN;
    logic [2:0] ew_in = L_RED;
    logic       clr = 1'b0;
    logic [2:0] ns_out, ew_out;
    logic       fault_out;
    logic [2:0] code_out;

    int total = 0;
    int bad = 0;

    light_conflict_monitor #(
        .MIN_YELLOW     (MIN_YELLOW),
        .FAULT_PERSIST  (FAULT_PERSIST),
        .FLASH_HALF     (FLASH_HALF),
        .STARTUP_CYCLES (STARTUP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .NS_light_in (ns_in),
        .EW_light_in (ew_in),
        .fault_clr   (clr),
        .NS_light    (ns_out),
        .EW_light    (ew_out),
        .fault       (fault_out),
        .fault_code  (code_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model: raw sample history per direction plus phase bookkeeping.
    logic [2:0] ns_hist[$];
    logic [2:0] ew_hist[$];
    bit         m_valid = 0;
    int         red_left;
    bit         flashing;
    int         age;
    int         err_run;
    logic [2:0] e_ns, e_ew, e_code;

    function automatic logic [2:0] prev_ns();
        return (ns_hist.size() == 0) ? L_RED : ns_hist[ns_hist.size() - 1];
    endfunction

    function automatic logic [2:0] prev_ew();
        return (ew_hist.size() == 0) ? L_RED : ew_hist[ew_hist.size() - 1];
    endfunction

    function automatic int yel_run(input bit is_ns);
        int n = 0;
        if (is_ns) begin
            for (int i = ns_hist.size() - 1; i >= 0 && ns_hist[i] == L_YEL; i--) n++;
        end else begin
            for (int i = ew_hist.size() - 1; i >= 0 && ew_hist[i] == L_YEL; i--) n++;
        end
        return n;
    endfunction

    function automatic bit legal(input logic [2:0] v);
        return v == L_RED || v == L_YEL || v == L_GRN;
    endfunction

    function automatic int classify(input logic [2:0] n, input logic [2:0] e);
        if (!legal(n) || !legal(e)) return 1;
        if (n != L_RED && e != L_RED) return 2;
        if ((prev_ns() == L_GRN && n == L_RED) || (prev_ew() == L_GRN && e == L_RED)) return 3;
        if ((prev_ns() == L_YEL && n != L_YEL && yel_run(1) < MIN_YELLOW) ||
            (prev_ew() == L_YEL && e != L_YEL && yel_run(0) < MIN_YELLOW)) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        int c;
        m_valid = 1;
        if (rst) begin
            ns_hist.delete();
            ew_hist.delete();
            red_left = STARTUP_CYCLES - 1;
            flashing = 0;
            age = 0;
            err_run = 0;
            e_code = 3'd0;
            e_ns = L_RED;
            e_ew = L_RED;
        end else begin
            e_ns = L_RED;
            e_ew = L_RED;
            if (flashing) begin
                if (clr) begin
                    flashing = 0;
                    e_code = 3'd0;
                    red_left = STARTUP_CYCLES - 1;
                end else begin
                    age++;
                    if ((age % (2 * FLASH_HALF)) >= FLASH_HALF) begin
                        e_ns = L_OFF;
                        e_ew = L_OFF;
                    end
                end
            end else if (red_left > 0) begin
                red_left--;
                err_run = 0;
            end else begin
                c = classify(ns_in, ew_in);
                if (c == 1 || c == 2) err_run++;
                else err_run = 0;
                if ((c == 1 || c == 2) && err_run < FAULT_PERSIST) begin
                    // masked: stays red
                end else if (c != 0) begin
                    flashing = 1;
                    age = 0;
                    err_run = 0;
                    e_code = 3'(c);
                end else begin
                    e_ns = ns_in;
                    e_ew = ew_in;
                end
            end
            ns_hist.push_back(ns_in);
            ew_hist.push_back(ew_in);
            if (ns_hist.size() > 16) void'(ns_hist.pop_front());
            if (ew_hist.size() > 16) void'(ew_hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ns", ns_out, e_ns);
            chk("model_ew", ew_out, e_ew);
            chk("model_fault", {2'b00, fault_out}, {2'b00, flashing});
            chk("model_code", code_out, e_code);
        end
    end

    task automatic step(input logic [2:0] n, input logic [2:0] e, input logic c);
        ns_in = n;
        ew_in = e;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cnt, input logic [2:0] n, input logic [2:0] e);
        for (int i = 0; i < cnt; i++) step(n, e, 1'b0);
    endtask

    initial begin
        // Reset and legal cycle
        step(L_GRN, L_RED, 1'b0);
        step(L_GRN, L_RED, 1'b0);
        chk("reset_ns", ns_out, L_RED);
        chk("reset_fault", {2'b00, fault_out}, 3'd0);
        chk("reset_code", code_out, 3'd0);
        rst = 1'b0;
        run(7, L_GRN, L_RED);
        chk("startup_last_red", ns_out, L_RED);
        step(L_GRN, L_RED, 1'b0);
        chk("first_pass", ns_out, L_GRN);
        run(3, L_YEL, L_RED);
        chk("yel_pass", ns_out, L_YEL);
        step(L_RED, L_RED, 1'b1);
        chk("yel3_clean", code_out, 3'd0);
        run(2, L_RED, L_GRN);
        run(3, L_RED, L_YEL);
        run(1, L_RED, L_RED);
        chk("ew_cycle_fault", {2'b00, fault_out}, 3'd0);

        // Conflict persisting two samples
        step(L_GRN, L_GRN, 1'b0);
        chk("conflict_mask", ns_out, L_RED);
        chk("conflict_no_fault", {2'b00, fault_out}, 3'd0);
        step(L_GRN, L_GRN, 1'b0);
        chk("conflict_fault", {2'b00, fault_out}, 3'd1);
        chk("conflict_code", code_out, 3'd2);
        run(3, L_RED, L_RED);
        chk("flash_red_end", ns_out, L_RED);
        run(1, L_RED, L_RED);
        chk("flash_off", ew_out, L_OFF);
        run(4, L_RED, L_RED);
        chk("flash_red_again", ns_out, L_RED);
        step(L_RED, L_RED, 1'b1);
        chk("clear_fault", {2'b00, fault_out}, 3'd0);
        chk("clear_code", code_out, 3'd0);

        // Green straight to red
        run(8, L_GRN, L_RED);
        chk("pass_after_clear", ns_out, L_GRN);
        step(L_RED, L_RED, 1'b0);
        chk("skip_code", code_out, 3'd3);
        chk("skip_ns_red", ns_out, L_RED);

        // Short yellow
        step(L_RED, L_RED, 1'b1);
        run(8, L_RED, L_RED);
        step(L_GRN, L_RED, 1'b0);
        run(2, L_YEL, L_RED);
        step(L_RED, L_RED, 1'b0);
        chk("short_code", code_out, 3'd4);

        // Bad encoding: single cycle masked, two cycles latch
        step(L_RED, L_RED, 1'b1);
        run(8, L_RED, L_RED);
        step(L_BAD, L_RED, 1'b0);
        chk("enc_mask", ns_out, L_RED);
        chk("enc_no_fault", {2'b00, fault_out}, 3'd0);
        step(L_RED, L_GRN, 1'b0);
        chk("enc_recover", ew_out, L_GRN);
        run(2, L_BAD, L_GRN);
        chk("enc_code", code_out, 3'd1);

        // Reset wins over clear mid-flash
        run(2, L_RED, L_RED);
        rst = 1'b1;
        step(L_RED, L_RED, 1'b1);
        chk("rst_fault", {2'b00, fault_out}, 3'd0);
        chk("rst_code", code_out, 3'd0);
        chk("rst_ew", ew_out, L_RED);
        rst = 1'b0;
        run(8, L_GRN, L_RED);
        chk("post_rst_pass", ns_out, L_GRN);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
